// File: rtl/hamming_ser_enc.sv
// Serial Hamming / SECDED encoder: accepts a K-bit word, builds the codeword
// and streams it one bit per out_valid/out_ready transfer.
module hamming_ser_enc #(
    parameter int K         = 128,
    parameter int SECDED    = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_bit,
    output logic         out_sof,
    output logic         out_eof,
    output logic         busy
);
    function automatic int unsigned calc_r(input int unsigned k);
        int unsigned res;
        res = 16;
        for (int unsigned r = 15; r >= 1; r--)
            if ((32'd1 << r) >= k + r + 1) res = r;
        return res;
    endfunction

    localparam int unsigned R  = calc_r(K);
    localparam int unsigned M  = K + R;
    localparam int unsigned N  = M + SECDED;
    localparam int unsigned LO = 1 - SECDED;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned PW = $clog2(M + 1);
    localparam int unsigned OW = $clog2(N);
    localparam int unsigned DW = $clog2(K);

    typedef enum logic [1:0] {IDLE, CALC, SHIFT} state_t;

    state_t          r_state;
    logic [K-1:0]    r_data;
    logic [N-1:0]    r_sr;
    logic [CW-1:0]   r_cnt;
    logic            r_valid;
    logic            r_sof;
    logic            r_eof;
    logic            r_rdy;

    logic [M:0]      w_dpos;
    logic [R-1:0]    w_par;
    logic [M:0]      w_cw;
    logic [N-1:0]    w_order;

    // Data bits fill every non-power-of-two position, din[0] landing on 3.
    always_comb begin
        int unsigned d;
        w_dpos = '0;
        d = 0;
        for (int unsigned p = 1; p <= M; p++) begin
            if ((p & (p - 1)) != 0) begin
                w_dpos[p[PW-1:0]] = r_data[d[DW-1:0]];
                d++;
            end
        end
    end

    always_comb begin
        w_par = '0;
        for (int unsigned i = 0; i < R; i++)
            for (int unsigned p = 1; p <= M; p++)
                if (((p >> i) & 1) != 0)
                    w_par[i] = w_par[i] ^ w_dpos[p[PW-1:0]];
    end

    always_comb begin
        int unsigned q;
        w_cw = w_dpos;
        q = 0;
        for (int unsigned i = 0; i < R; i++) begin
            q = 32'd1 << i;
            w_cw[q[PW-1:0]] = w_par[i];
        end
        if (SECDED != 0)
            w_cw[0] = (^w_dpos) ^ (^w_par);
    end

    // Shift register head (bit N-1) is always the next bit on the wire.
    always_comb begin
        int unsigned s;
        int unsigned t;
        w_order = '0;
        s = 0;
        t = 0;
        for (int unsigned j = 0; j < N; j++) begin
            s = j + LO;
            t = (MSB_FIRST != 0) ? j : (N - 1 - j);
            w_order[t[OW-1:0]] = w_cw[s[PW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rdy <= 1'b1;
                    if (in_valid && r_rdy) begin
                        r_data  <= din;
                        r_rdy   <= 1'b0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_sr    <= w_order;
                    r_cnt   <= CW'(N);
                    r_sof   <= 1'b1;
                    r_eof   <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (out_ready) begin
                        if (r_cnt == CW'(1)) begin
                            r_state <= IDLE;
                            r_sr    <= '0;
                            r_valid <= 1'b0;
                            r_sof   <= 1'b0;
                            r_eof   <= 1'b0;
                            r_rdy   <= 1'b1;
                        end else begin
                            r_sr  <= {r_sr[N-2:0], 1'b0};
                            r_cnt <= r_cnt - 1'b1;
                            r_sof <= 1'b0;
                            r_eof <= (r_cnt == CW'(2));
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_rdy;
    assign out_valid = r_valid;
    assign out_bit   = r_sr[N-1];
    assign out_sof   = r_sof;
    assign out_eof   = r_eof;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_hamming_ser_enc.sv
// Bench for hamming_ser_enc: four parameterisations share the stimulus and each
// stream is compared against a codeword model built from the position rules.
module tb_hamming_ser_enc;
    localparam int NI = 4;

    logic clk;
    logic reset, in_valid, out_ready;
    logic [127:0] din_v [NI];
    logic [NI-1:0] ir, ov, ob, sf, ef, bz;

    int checks = 0;
    int errors = 0;
    int kk [NI] = '{128, 4, 128, 4};
    int ss [NI] = '{1, 0, 1, 1};
    int mm [NI] = '{1, 1, 0, 1};
    bit exp_q [NI][$];
    bit got_q [NI][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hamming_ser_enc #(.K(128), .SECDED(1), .MSB_FIRST(1)) u_def (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
        .din(din_v[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .out_bit(ob[0]), .out_sof(sf[0]), .out_eof(ef[0]), .busy(bz[0]));
    hamming_ser_enc #(.K(4), .SECDED(0), .MSB_FIRST(1)) u_k4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
        .din(din_v[1][3:0]), .out_valid(ov[1]), .out_ready(out_ready),
        .out_bit(ob[1]), .out_sof(sf[1]), .out_eof(ef[1]), .busy(bz[1]));
    hamming_ser_enc #(.K(128), .SECDED(1), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]),
        .din(din_v[2]), .out_valid(ov[2]), .out_ready(out_ready),
        .out_bit(ob[2]), .out_sof(sf[2]), .out_eof(ef[2]), .busy(bz[2]));
    hamming_ser_enc #(.K(4), .SECDED(1), .MSB_FIRST(1)) u_k4s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[3]),
        .din(din_v[3][3:0]), .out_valid(ov[3]), .out_ready(out_ready),
        .out_bit(ob[3]), .out_sof(sf[3]), .out_eof(ef[3]), .busy(bz[3]));

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Codeword as an array of positions, then read out in wire order.
    function automatic void build_exp(input int i, input logic [127:0] d);
        bit cw [0:255];
        int r, pos, di, ones, lo;
        r = 0;
        while ((1 << r) < kk[i] + r + 1) r++;
        for (int p = 0; p < 256; p++) cw[p] = 1'b0;
        di = 0;
        for (pos = 1; pos <= kk[i] + r; pos++)
            if ($countones(pos) != 1) begin
                cw[pos] = d[di];
                di++;
            end
        for (int b = 0; b < r; b++) begin
            ones = 0;
            for (pos = 1; pos <= kk[i] + r; pos++)
                if (((pos >> b) & 1) == 1 && $countones(pos) != 1) ones += int'(cw[pos]);
            cw[1 << b] = ones[0];
        end
        ones = 0;
        for (pos = 1; pos <= kk[i] + r; pos++) ones += int'(cw[pos]);
        cw[0] = ones[0];
        lo = (ss[i] != 0) ? 0 : 1;
        exp_q[i].delete();
        if (mm[i] != 0)
            for (pos = kk[i] + r; pos >= lo; pos--) exp_q[i].push_back(cw[pos]);
        else
            for (pos = lo; pos <= kk[i] + r; pos++) exp_q[i].push_back(cw[pos]);
    endfunction

    task automatic run_frame(input bit stall, input bit chaos, input int abort_at);
        int cnt [NI];
        bit done [NI], held [NI], irchk [NI];
        bit hb [NI], hs [NI], he [NI];
        int guard, bad;
        bit all_done;
        for (int i = 0; i < NI; i++) begin
            build_exp(i, din_v[i]);
            got_q[i].delete();
            cnt[i] = 0; done[i] = 0; held[i] = 0; irchk[i] = 0;
            hb[i] = 0; hs[i] = 0; he[i] = 0;
        end
        guard = 0;
        while (ir !== '1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (ir !== '1) begin
            errors++;
            $display("FAIL ready_wait: in_ready=%b required 1111", ir);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        if (!chaos) in_valid = 1'b0;
        checks++;
        if (ov !== '0 || ir !== '0 || bz !== '1) begin
            errors++;
            $display("FAIL calc_cycle: valid=%b ready=%b busy=%b required 0000 0000 1111", ov, ir, bz);
        end
        guard = 0;
        all_done = 0;
        while (!all_done && guard < 2000) begin
            @(negedge clk);
            if (guard == 0) begin
                checks++;
                if (ov !== '1) begin
                    errors++;
                    $display("FAIL first_valid: out_valid=%b required 1111", ov);
                end
            end
            guard++;
            if (abort_at > 0 && cnt[0] == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                checks++;
                if (ov !== '0 || sf !== '0 || ef !== '0 || ob !== '0 || bz !== '0 || done[0]) begin
                    errors++;
                    $display("FAIL mid_reset: valid=%b sof=%b eof=%b bit=%b busy=%b eof_seen=%0d required all 0",
                             ov, sf, ef, ob, bz, done[0]);
                end
                reset = 1'b0;
                in_valid = 1'b0;
                return;
            end
            if (chaos) begin
                in_valid = 1'b1;
                for (int i = 0; i < NI; i++) din_v[i] = rand128();
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (ov[i] === 1'b0) begin
                    checks++;
                    if ({ob[i], sf[i], ef[i]} !== 3'b000) begin
                        errors++;
                        $display("FAIL quiet_outputs[%0d]: bit/sof/eof=%b%b%b required 000", i, ob[i], sf[i], ef[i]);
                    end
                end
                if (irchk[i]) begin
                    checks++;
                    irchk[i] = 0;
                    if (ir[i] !== 1'b1 || ov[i] !== 1'b0) begin
                        errors++;
                        $display("FAIL ready_after_eof[%0d]: in_ready=%b valid=%b required 1 0", i, ir[i], ov[i]);
                    end
                end
                if (done[i]) continue;
                if (held[i]) begin
                    checks++;
                    held[i] = 0;
                    if (ov[i] !== 1'b1 || ob[i] !== hb[i] || sf[i] !== hs[i] || ef[i] !== he[i]) begin
                        errors++;
                        $display("FAIL stall_hold[%0d]: v/b/s/e=%b%b%b%b required 1%b%b%b",
                                 i, ov[i], ob[i], sf[i], ef[i], hb[i], hs[i], he[i]);
                    end
                end
                if (bz[i] === 1'b1) begin
                    checks++;
                    if (ir[i] !== 1'b0) begin
                        errors++;
                        $display("FAIL ready_while_busy[%0d]: in_ready=%b required 0", i, ir[i]);
                    end
                end
                if (ov[i] === 1'b1 && out_ready) begin
                    checks++;
                    if (sf[i] !== (cnt[i] == 0) || ef[i] !== (cnt[i] == exp_q[i].size() - 1)) begin
                        errors++;
                        $display("FAIL markers[%0d] bit %0d: sof=%b eof=%b required %b %b", i, cnt[i],
                                 sf[i], ef[i], (cnt[i] == 0), (cnt[i] == exp_q[i].size() - 1));
                    end
                    got_q[i].push_back(ob[i]);
                    cnt[i]++;
                    if (ef[i] === 1'b1) begin
                        done[i] = 1;
                        irchk[i] = 1;
                    end
                end else if (ov[i] === 1'b1) begin
                    held[i] = 1;
                    hb[i] = ob[i]; hs[i] = sf[i]; he[i] = ef[i];
                end
            end
            all_done = 1;
            for (int i = 0; i < NI; i++) all_done &= done[i];
        end
        checks++;
        if (!all_done) begin
            errors++;
            $display("FAIL frame_timeout: eof seen %0d%0d%0d%0d required 1111", done[0], done[1], done[2], done[3]);
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            if (irchk[i]) begin
                checks++;
                if (ir[i] !== 1'b1 || ov[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_after_eof[%0d]: in_ready=%b valid=%b required 1 0", i, ir[i], ov[i]);
                end
            end
            checks++;
            if (got_q[i].size() != exp_q[i].size()) begin
                errors++;
                $display("FAIL frame_len[%0d]: got %0d bits required %0d", i, got_q[i].size(), exp_q[i].size());
            end
            bad = 0;
            for (int j = 0; j < got_q[i].size() && j < exp_q[i].size(); j++)
                if (got_q[i][j] != exp_q[i][j]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL frame_bits[%0d]: %0d bits differ required 0", i, bad);
            end
        end
        in_valid = 1'b0;
        guard = 0;
        while (bz !== '0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (bz !== '0) begin
            errors++;
            $display("FAIL drain: busy=%b required 0000", bz);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < NI; i++) din_v[i] = rand128();
        repeat (3) @(negedge clk);
        checks++;
        if (ir !== '0 || ov !== '0 || ob !== '0 || sf !== '0 || ef !== '0 || bz !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b v=%b b=%b s=%b e=%b busy=%b required all 0", ir, ov, ob, sf, ef, bz);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ir !== '1 || bz !== '0) begin
            errors++;
            $display("FAIL ready_after_reset: in_ready=%b busy=%b required 1111 0000", ir, bz);
        end
    endtask

    task automatic test_vectors();
        bit v7 [7] = '{1, 0, 1, 0, 1, 0, 1};
        bit v8 [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        int bad;
        din_v[0] = 128'h1;
        din_v[1] = 128'hB;
        din_v[2] = 128'h1;
        din_v[3] = 128'hB;
        run_frame(1'b0, 1'b0, 0);
        bad = (got_q[1].size() == 7) ? 0 : 1;
        for (int j = 0; j < 7 && j < got_q[1].size(); j++) if (got_q[1][j] != v7[j]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL vec_k4_hamming: %0d discrepancies (len %0d) required 0", bad, got_q[1].size());
        end
        bad = (got_q[3].size() == 8) ? 0 : 1;
        for (int j = 0; j < 8 && j < got_q[3].size(); j++) if (got_q[3][j] != v8[j]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL vec_k4_secded: %0d discrepancies (len %0d) required 0", bad, got_q[3].size());
        end
        bad = (got_q[2].size() == 137) ? 0 : 1;
        for (int j = 0; j < got_q[2].size(); j++) if (got_q[2][j] != (j < 4)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL vec_k128_lsb: %0d discrepancies (len %0d) required 0", bad, got_q[2].size());
        end
        bad = (got_q[0].size() == 137) ? 0 : 1;
        for (int j = 0; j < got_q[0].size(); j++) if (got_q[0][j] != (j >= 133)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL vec_k128_msb: %0d discrepancies (len %0d) required 0", bad, got_q[0].size());
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NI; i++) din_v[i] = rand128();
            run_frame(1'b0, 1'b0, 0);
        end
    endtask

    task automatic test_stall();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NI; i++) din_v[i] = rand128();
            run_frame(1'b1, 1'b0, 0);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NI; i++) din_v[i] = rand128();
            run_frame(f[0], 1'b1, 0);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < NI; i++) din_v[i] = rand128();
        run_frame(1'b0, 1'b0, 50);
        for (int i = 0; i < NI; i++) din_v[i] = rand128();
        run_frame(1'b0, 1'b0, 0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NI; i++) din_v[i] = '0;
        test_reset();
        test_vectors();
        test_random();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
